ota_diff_pwm_tx: RTL and testbench

OTA_DIFF_PWM_TX -- requirements
Module: ota_diff_pwm_tx

---
 rtl/ota_diff_pwm_tx_pkg.sv | 13 +
 rtl/ota_diff_pwm_tx_if.sv | 25 ++
 rtl/ota_diff_pwm_tx_period_cnt.sv | 21 ++
 rtl/ota_diff_pwm_tx.sv | 101 ++++++++++
 tb/tb_ota_diff_pwm_tx.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/ota_diff_pwm_tx_pkg.sv
// Shared definitions for the OTA differential PWM drive path and its
// comparator-side companions.
package ota_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ota_state_e;

    localparam int OTA_CNT_W = 8;
    localparam int OTA_DEAD  = 2;

endpackage

// File: rtl/ota_diff_pwm_tx_if.sv
// Code handshake plus differential drive outputs of ota_diff_pwm_tx.
interface ota_diff_pwm_tx_if
    import ota_pkg::*;
#(
    parameter int CNT_W = OTA_CNT_W
);
    logic [CNT_W-1:0] code_data;
    logic             code_valid;
    logic             code_ready;
    logic             stop;
    logic             vip;
    logic             vin;
    logic             period_done;
    logic             busy;

    modport master (
        output code_data, code_valid, stop,
        input  code_ready, vip, vin, period_done, busy
    );

    modport slave (
        input  code_data, code_valid, stop,
        output code_ready, vip, vin, period_done, busy
    );
endinterface

// File: rtl/ota_diff_pwm_tx_period_cnt.sv
// Free-running period counter: counts while enabled, parks at zero otherwise.
// Exposes the next count so the caller can register outputs aligned to k.
module ota_period_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_nxt_o,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q;

    assign cnt_nxt_o = en_i ? cnt_q + 1'b1 : '0;
    assign tc_o      = en_i && (cnt_q == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_nxt_o;
    end
endmodule

// File: rtl/ota_diff_pwm_tx.sv
// Differential PWM driver: vip high for duty_q cycles, vin high for the
// complementary window trimmed by DEAD cycles on both edges.
module ota_diff_pwm_tx
    import ota_pkg::*;
#(
    parameter int CNT_W = OTA_CNT_W,
    parameter int DEAD  = OTA_DEAD
) (
    input  logic               clk,
    input  logic               rst_n,
    ota_diff_pwm_tx_if.slave   bus
);
    localparam int CW = CNT_W + 2;
    localparam logic [CW-1:0] P_X    = CW'(1) << CNT_W;
    localparam logic [CW-1:0] DEAD_X = CW'(DEAD);

    ota_state_e       state_q, state_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             stop_pend_q, stop_pend_d;
    logic             vip_q, vip_d;
    logic             vin_q, vin_d;
    logic             rdy_en_q;
    logic [CNT_W-1:0] k_nxt;
    logic             tc;
    logic             code_ready;
    logic             accept;
    logic             run_d;
    logic [CW-1:0]    k_x, duty_x;

    ota_period_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (state_q == RUN),
        .cnt_nxt_o (k_nxt),
        .tc_o      (tc)
    );

    // rdy_en_q keeps code_ready low through reset and its release edge
    assign code_ready      = rdy_en_q && ((state_q == IDLE) || tc);
    assign accept          = bus.code_valid && code_ready;
    assign bus.code_ready  = code_ready;
    assign bus.busy        = (state_q == RUN);
    assign bus.period_done = tc;
    assign bus.vip         = vip_q;
    assign bus.vin         = vin_q;

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        stop_pend_d = stop_pend_q;
        unique case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (accept) begin
                    state_d = RUN;
                    duty_d  = bus.code_data;
                end
            end
            RUN: begin
                if (bus.stop) stop_pend_d = 1'b1;
                if (tc) begin
                    if (accept) begin
                        duty_d      = bus.code_data;
                        stop_pend_d = 1'b0;
                    end else if (stop_pend_q) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-cycle k/duty so they switch cleanly
    always_comb begin
        run_d  = (state_d == RUN);
        k_x    = CW'(k_nxt);
        duty_x = CW'(duty_d);
        vip_d  = run_d && (k_x < duty_x);
        vin_d  = run_d && (k_x >= duty_x + DEAD_X) && (k_x < P_X - DEAD_X);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            duty_q      <= '0;
            stop_pend_q <= 1'b0;
            vip_q       <= 1'b0;
            vin_q       <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            stop_pend_q <= stop_pend_d;
            vip_q       <= vip_d;
            vin_q       <= vin_d;
            rdy_en_q    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ota_diff_pwm_tx.sv
// Directed bench for ota_diff_pwm_tx at CNT_W=8, DEAD=2.
module tb_ota_diff_pwm_tx;
    localparam int CNT_W = 8;
    localparam int DEAD  = 2;
    localparam int P     = 1 << CNT_W;

    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;
    int   gap;
    bit   have_pd;

    ota_diff_pwm_tx_if #(.CNT_W(CNT_W)) bus ();

    ota_diff_pwm_tx #(.CNT_W(CNT_W), .DEAD(DEAD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        vecs++;
        assert (got === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
        end
    endtask

    // Always-on properties: exclusive drive and period_done spacing
    always @(negedge clk) begin
        if (!rst_n) begin
            have_pd = 1'b0;
            gap     = 0;
        end else begin
            chk("vip_vin_excl", bus.vip && bus.vin, 1'b0);
            if (!bus.busy) begin
                have_pd = 1'b0;
                gap     = 0;
            end else begin
                gap++;
                if (bus.period_done) begin
                    if (have_pd) chk($sformatf("pd_gap_%0d", gap), gap == P, 1'b1);
                    have_pd = 1'b1;
                    gap     = 0;
                end
            end
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_vip"}, bus.vip, 1'b0);
        chk({tag, "_vin"}, bus.vin, 1'b0);
        chk({tag, "_pd"}, bus.period_done, 1'b0);
        chk({tag, "_rdy"}, bus.code_ready, 1'b1);
    endtask

    // Entered just after the edge that starts k=0; returns just after the
    // edge that ends k=P-1 (or right after asserting reset at rst_k).
    task automatic run_period(input int duty, input int chg_k, input int chg_data,
                              input int stop_k, input int rst_k);
        logic vip_e, vin_e, last;
        for (int k = 0; k < P; k++) begin
            @(negedge clk);
            vip_e = (k < duty);
            vin_e = (k >= duty + DEAD) && (k < P - DEAD);
            last  = (k == P - 1);
            chk($sformatf("vip_d%0d_k%0d", duty, k), bus.vip, vip_e);
            chk($sformatf("vin_d%0d_k%0d", duty, k), bus.vin, vin_e);
            chk($sformatf("pd_d%0d_k%0d", duty, k), bus.period_done, last);
            chk($sformatf("rdy_d%0d_k%0d", duty, k), bus.code_ready, last);
            chk($sformatf("busy_d%0d_k%0d", duty, k), bus.busy, 1'b1);
            if (k == chg_k) begin
                bus.code_data  = CNT_W'(chg_data);
                bus.code_valid = 1'b1;
            end
            if (k == stop_k)     bus.stop = 1'b1;
            if (k == stop_k + 1) bus.stop = 1'b0;
            if (k == rst_k) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rst_async_vip", bus.vip, 1'b0);
                chk("rst_async_vin", bus.vin, 1'b0);
                chk("rst_async_busy", bus.busy, 1'b0);
                chk("rst_async_pd", bus.period_done, 1'b0);
                chk("rst_async_rdy", bus.code_ready, 1'b0);
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int code);
        @(posedge clk);
        #1;
        bus.code_data  = CNT_W'(code);
        bus.code_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.code_valid = 1'b0;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst_n          = 1'b0;
        bus.code_data  = '0;
        bus.code_valid = 1'b0;
        bus.stop       = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", bus.code_ready, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_vip", bus.vip, 1'b0);
        chk("rst_vin", bus.vin, 1'b0);
        chk("rst_pd", bus.period_done, 1'b0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle("post_rst");

        // stop is ignored in IDLE
        bus.stop = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle("idle_stop");
        end
        bus.stop = 1'b0;

        // code 64 repeats, then code 0 loaded at the period boundary
        start(64);
        run_period(64, -1, 0, -1, -1);
        run_period(64, P - 1, 0, -1, -1);
        bus.code_valid = 1'b0;

        // stop pending but a code at k=P-1 still wins
        run_period(0, P - 1, 255, 100, -1);
        bus.code_valid = 1'b0;
        run_period(255, -1, 0, 100, -1);
        @(negedge clk);
        chk_idle("after_255");

        // held code 10, code 200 offered from k5 and taken at k=P-1
        @(posedge clk);
        #1;
        bus.code_data  = 8'd10;
        bus.code_valid = 1'b1;
        @(posedge clk);
        #1;
        run_period(10, 5, 200, -1, -1);
        bus.code_valid = 1'b0;
        run_period(200, -1, 0, 100, -1);
        @(negedge clk);
        chk_idle("after_200");

        // stop at k100 with code 64 finishes the period then idles
        start(64);
        run_period(64, -1, 0, 100, -1);
        @(negedge clk);
        chk_idle("after_stop64");

        // reset mid-period; old duty must not resume
        start(64);
        run_period(64, -1, 0, -1, 120);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        repeat (6) begin
            @(negedge clk);
            chk_idle("post_abort");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
